conv_loop_ctrl: RTL and testbench
=================================

# conv_loop_ctrl

Parametrised convolution loop controller for the conv datapath. It walks every output pixel and output channel of a 2-D convolution with configurable stride, padding, input/output channel count and MAC pipeline depth. It issues bias, input, weight and output addresses plus the datapath strobes: bias load, read, zero-pad, MAC, saturate and write. It adds a start/busy/done handshake, a memory stall input and explicit padding detection, so padded taps inject zero instead of reading memory. It sits between the layer sequencer and the conv MAC/saturation datapath.

## Interface
- DIM_IN, 32: input image height/width (square)
- DIM_OUT, 32: output image height/width
- DIM_K, 5: kernel height/width
- IN_CH, 3: input channels
- OUT_CH, 32: output channels
- STRIDE, 1: convolution stride
- PADDING, 2: zero padding on each border
- MAC_LAT, 2: cycles from tap issue to MAC enable (memory read latency), ≥1
- ADDR_W, 16: address width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a layer; sampled only in IDLE
- stall  in  1  memory not ready; freezes controller this cycle
- busy  out  1  high from the first cycle after start is accepted until done
- done  out  1  one-cycle pulse at layer end
- s_addr  out  ADDR_W  input address, HWC: (in_row*DIM_IN+in_col)*IN_CH+ic
- w_addr  out  ADDR_W  weight address: ((oc*DIM_K+kr)*DIM_K+kc)*IN_CH+ic
- b_addr  out  ADDR_W  bias address = oc
- save_addr  out  ADDR_W  output address: (orow*DIM_OUT+ocol)*OUT_CH+oc
- en_bias  out  1  load bias into accumulator
- en_read  out  1  tap in bounds; read s_addr and w_addr
- pad_zero  out  1  tap in padding; datapath uses input 0
- en_mac  out  1  accumulate; delayed issue strobe
- en_sat  out  1  saturate accumulator
- en_write  out  1  write saturated result to save_addr

## Operation
- Loops, outer to inner: orow, ocol, oc | kr, kc, ic. Counters are 8-bit. TAPS = DIM_K*DIM_K*IN_CH.
- in_row = orow*STRIDE − PADDING + kr, and likewise in_col with ocol/kc. Both are computed as signed 9-bit values. The tap is padded if either is < 0 or ≥ DIM_IN.
- Padded taps force s_addr = 0. w_addr is still driven.
- States and transitions:
  - IDLE: start=1 → BIAS.
  - BIAS: 1 cycle, en_bias=1 → ACC.
  - ACC: TAPS cycles, one tap per cycle. Exactly one of en_read or pad_zero is high. After the last tap → DRAIN.
  - DRAIN: MAC_LAT cycles, no issue strobes → SAT.
  - SAT: en_sat=1 → WRITE.
  - WRITE: en_write=1. Advance oc, then ocol, then orow. If all loops are complete → DONE, else → BIAS.
  - DONE: done=1, busy=0 → IDLE.
- en_mac is (en_read|pad_zero) delayed by an MAC_LAT-deep shift register.
- State and counters are registered. Strobes and addresses are decoded from them.
- Address arithmetic is done at full width, then truncated to ADDR_W. Parameter sets needing more than ADDR_W bits are illegal.

## Timing
- Reset (asynchronous): state=IDLE, all counters 0, shift register 0. All outputs 0, including addresses.
- start high at edge t → BIAS in cycle t+1, busy=1 from t+1.
- Per output point: 1 + TAPS + MAC_LAT + 2 cycles. Total busy cycles = DIM_OUT²·OUT_CH·(TAPS+MAC_LAT+3). done follows in the next cycle.
- stall=1 in any non-IDLE state:
  - state, counters and shift register hold;
  - en_bias, en_read, pad_zero, en_mac, en_sat, en_write and done are forced 0;
  - addresses hold.
- Operation resumes in the cycle after stall drops.
- start while busy or in DONE: ignored. start held high continuously: a new layer begins in the cycle after the IDLE that follows done.
- Reset asserted mid-layer: controller returns immediately to IDLE with all outputs 0. No done pulse.
- Last MAC of a point (en_mac) occurs in the final DRAIN cycle, before en_sat.

## Test plan
- DIM_IN=DIM_OUT=4, K=3, IN_CH=OUT_CH=1, STRIDE=1, PAD=1, MAC_LAT=2 → 14 cycles per point, busy for 224 cycles, a single done pulse. save_addr runs 0..15 in order.
- Same configuration, first point (0,0) → 5 pad_zero and 4 en_read taps. The first en_read has s_addr=0 and w_addr=4. en_mac count = 9, each lagging its issue by 2 cycles.
- IN_CH=2, OUT_CH=3, STRIDE=2, PAD=0, DIM_IN=5, DIM_OUT=2, K=3 → no pad_zero at all. b_addr cycles 0,1,2 per pixel. save_addr of point (1,1,oc=2) = 11.
- Stall pulses of 1 and 3 cycles injected in ACC, DRAIN and WRITE → strobe counts unchanged, total cycles increase by exactly the stalled count, and addresses are frozen during each stall.
- Reset asserted mid-ACC → all outputs 0 immediately, no done. A following start runs a full layer correctly.
- start asserted in the DONE cycle and during busy → ignored. start held high → back-to-back layers separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/conv_loop_ctrl.sv
// Loop controller for the convolution datapath.
// Walks orow/ocol/oc (outer) and kr/kc/ic (inner taps), producing input,
// weight, bias and output addresses plus the bias/read/pad/MAC/saturate/write
// strobes. Padded taps are flagged so the datapath injects zero instead of
// reading memory. A stall input freezes all state and masks every strobe.
module conv_loop_ctrl #(
    parameter int DIM_IN  = 32,
    parameter int DIM_OUT = 32,
    parameter int DIM_K   = 5,
    parameter int IN_CH   = 3,
    parameter int OUT_CH  = 32,
    parameter int STRIDE  = 1,
    parameter int PADDING = 2,
    parameter int MAC_LAT = 2,
    parameter int ADDR_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              stall_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [ADDR_W-1:0] b_addr_o,
    output logic [ADDR_W-1:0] save_addr_o,
    output logic              en_bias_o,
    output logic              en_read_o,
    output logic              pad_zero_o,
    output logic              en_mac_o,
    output logic              en_sat_o,
    output logic              en_write_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_ACC,
        ST_DRAIN,
        ST_SAT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Terminal values of each 8-bit loop counter.
    localparam logic [7:0] K_LAST  = 8'(DIM_K - 1);
    localparam logic [7:0] IC_LAST = 8'(IN_CH - 1);
    localparam logic [7:0] OC_LAST = 8'(OUT_CH - 1);
    localparam logic [7:0] O_LAST  = 8'(DIM_OUT - 1);
    localparam logic [7:0] DR_LAST = 8'(MAC_LAT - 1);

    state_t             state_q, state_d;
    logic [7:0]         orow_q, orow_d;
    logic [7:0]         ocol_q, ocol_d;
    logic [7:0]         oc_q, oc_d;
    logic [7:0]         kr_q, kr_d;
    logic [7:0]         kc_q, kc_d;
    logic [7:0]         ic_q, ic_d;
    logic [7:0]         drain_q, drain_d;
    logic [MAC_LAT-1:0] mac_sr_q, mac_sr_d;

    logic               run;
    logic               last_tap;
    logic               last_point;
    logic signed [8:0]  in_row;
    logic signed [8:0]  in_col;
    logic               padded;

    assign run        = ~stall_i;
    assign last_tap   = (ic_q == IC_LAST) && (kc_q == K_LAST) && (kr_q == K_LAST);
    assign last_point = (oc_q == OC_LAST) && (ocol_q == O_LAST) && (orow_q == O_LAST);

    // State, loop counters and MAC delay line; all cleared by reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            orow_q   <= '0;
            ocol_q   <= '0;
            oc_q     <= '0;
            kr_q     <= '0;
            kc_q     <= '0;
            ic_q     <= '0;
            drain_q  <= '0;
            mac_sr_q <= '0;
        end else begin
            state_q  <= state_d;
            orow_q   <= orow_d;
            ocol_q   <= ocol_d;
            oc_q     <= oc_d;
            kr_q     <= kr_d;
            kc_q     <= kc_d;
            ic_q     <= ic_d;
            drain_q  <= drain_d;
            mac_sr_q <= mac_sr_d;
        end
    end

    // Next-state and counter advance; nothing moves while stalled outside IDLE.
    always_comb begin
        state_d = state_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        oc_d    = oc_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        ic_d    = ic_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_BIAS;
                end
            end
            ST_BIAS: begin
                if (run) begin
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (run) begin
                    if (ic_q == IC_LAST) begin
                        ic_d = '0;
                        if (kc_q == K_LAST) begin
                            kc_d = '0;
                            if (kr_q == K_LAST) begin
                                kr_d = '0;
                            end else begin
                                kr_d = kr_q + 8'd1;
                            end
                        end else begin
                            kc_d = kc_q + 8'd1;
                        end
                    end else begin
                        ic_d = ic_q + 8'd1;
                    end
                    if (last_tap) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (run) begin
                    if (drain_q == DR_LAST) begin
                        drain_d = '0;
                        state_d = ST_SAT;
                    end else begin
                        drain_d = drain_q + 8'd1;
                    end
                end
            end
            ST_SAT: begin
                if (run) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (run) begin
                    if (oc_q == OC_LAST) begin
                        oc_d = '0;
                        if (ocol_q == O_LAST) begin
                            ocol_d = '0;
                            if (orow_q == O_LAST) begin
                                orow_d = '0;
                            end else begin
                                orow_d = orow_q + 8'd1;
                            end
                        end else begin
                            ocol_d = ocol_q + 8'd1;
                        end
                    end else begin
                        oc_d = oc_q + 8'd1;
                    end
                    state_d = last_point ? ST_DONE : ST_BIAS;
                end
            end
            ST_DONE: begin
                if (run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // MAC delay line: a tap issued now reaches en_mac MAC_LAT active cycles later.
    always_comb begin
        mac_sr_d = mac_sr_q;
        if (run) begin
            mac_sr_d[0] = (state_q == ST_ACC);
            for (int i = 1; i < MAC_LAT; i++) begin
                mac_sr_d[i] = mac_sr_q[i-1];
            end
        end
    end

    // Input coordinates of the current tap; out of range means zero padding.
    always_comb begin
        in_row = 9'(int'(orow_q) * STRIDE - PADDING + int'(kr_q));
        in_col = 9'(int'(ocol_q) * STRIDE - PADDING + int'(kc_q));
        padded = (int'(in_row) < 0) || (int'(in_row) >= DIM_IN) ||
                 (int'(in_col) < 0) || (int'(in_col) >= DIM_IN);
    end

    // Address decode from the held counters, so addresses freeze during a stall.
    always_comb begin
        s_addr_o    = padded ? '0 :
                      ADDR_W'((int'(in_row) * DIM_IN + int'(in_col)) * IN_CH + int'(ic_q));
        w_addr_o    = ADDR_W'(((int'(oc_q) * DIM_K + int'(kr_q)) * DIM_K + int'(kc_q)) * IN_CH
                              + int'(ic_q));
        b_addr_o    = ADDR_W'(oc_q);
        save_addr_o = ADDR_W'((int'(orow_q) * DIM_OUT + int'(ocol_q)) * OUT_CH + int'(oc_q));
    end

    // Strobe decode; every strobe and done is masked while stalled.
    always_comb begin
        busy_o     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done_o     = (state_q == ST_DONE) && run;
        en_bias_o  = (state_q == ST_BIAS) && run;
        en_read_o  = (state_q == ST_ACC) && run && !padded;
        pad_zero_o = (state_q == ST_ACC) && run && padded;
        en_mac_o   = mac_sr_q[MAC_LAT-1] && run;
        en_sat_o   = (state_q == ST_SAT) && run;
        en_write_o = (state_q == ST_WRITE) && run;
    end

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Testbench for conv_loop_ctrl: two configurations, a cycle-level expected
// trace generated from the loop nest, random stalls and start noise.
module tb_conv_loop_ctrl;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        bias;
        logic        rd;
        logic        pz;
        logic        mac;
        logic        sat;
        logic        wr;
        logic [15:0] s;
        logic [15:0] w;
        logic [15:0] b;
        logic [15:0] sv;
    } obs_t;

    // Configuration 0 (A) and 1 (B).
    int c_din [2] = '{4, 5};
    int c_dout[2] = '{4, 2};
    int c_k   [2] = '{3, 3};
    int c_ic  [2] = '{1, 2};
    int c_oc  [2] = '{1, 3};
    int c_st  [2] = '{1, 2};
    int c_pd  [2] = '{1, 0};
    int c_lat [2] = '{2, 3};

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic stall = 1'b0;

    logic a_busy, a_done, a_bias, a_rd, a_pz, a_mac, a_sat, a_wr;
    logic [15:0] a_s, a_w, a_b, a_sv;
    logic b_busy, b_done, b_bias, b_rd, b_pz, b_mac, b_sat, b_wr;
    logic [15:0] b_s, b_w, b_b, b_sv;

    obs_t obs_a, obs_b, obs;
    int   sel = 0;
    int   total = 0;
    int   bad = 0;
    obs_t exp_q[$];
    obs_t zero_obs = '0;

    always #5 clk = ~clk;

    conv_loop_ctrl #(
        .DIM_IN(4), .DIM_OUT(4), .DIM_K(3), .IN_CH(1), .OUT_CH(1),
        .STRIDE(1), .PADDING(1), .MAC_LAT(2), .ADDR_W(16)
    ) dut_a (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_a), .stall_i(stall),
        .busy_o(a_busy), .done_o(a_done),
        .s_addr_o(a_s), .w_addr_o(a_w), .b_addr_o(a_b), .save_addr_o(a_sv),
        .en_bias_o(a_bias), .en_read_o(a_rd), .pad_zero_o(a_pz),
        .en_mac_o(a_mac), .en_sat_o(a_sat), .en_write_o(a_wr)
    );

    conv_loop_ctrl #(
        .DIM_IN(5), .DIM_OUT(2), .DIM_K(3), .IN_CH(2), .OUT_CH(3),
        .STRIDE(2), .PADDING(0), .MAC_LAT(3), .ADDR_W(16)
    ) dut_b (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_b), .stall_i(stall),
        .busy_o(b_busy), .done_o(b_done),
        .s_addr_o(b_s), .w_addr_o(b_w), .b_addr_o(b_b), .save_addr_o(b_sv),
        .en_bias_o(b_bias), .en_read_o(b_rd), .pad_zero_o(b_pz),
        .en_mac_o(b_mac), .en_sat_o(b_sat), .en_write_o(b_wr)
    );

    assign obs_a = {a_busy, a_done, a_bias, a_rd, a_pz, a_mac, a_sat, a_wr, a_s, a_w, a_b, a_sv};
    assign obs_b = {b_busy, b_done, b_bias, b_rd, b_pz, b_mac, b_sat, b_wr, b_s, b_w, b_b, b_sv};
    assign obs   = (sel == 0) ? obs_a : obs_b;

    task automatic chk(input string tag, input obs_t o, input obs_t e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic set_start(input bit v);
        if (sel == 0) start_a = v;
        else start_b = v;
    endtask

    function automatic bit is_pad(input int s, input int orow, input int ocol,
                                  input int kr, input int kc);
        int ir, icl;
        ir  = orow * c_st[s] - c_pd[s] + kr;
        icl = ocol * c_st[s] - c_pd[s] + kc;
        return (ir < 0) || (ir >= c_din[s]) || (icl < 0) || (icl >= c_din[s]);
    endfunction

    // Expected outputs for a busy cycle at the given loop position.
    function automatic obs_t mk(input int s, input int orow, input int ocol, input int oc,
                                input int kr, input int kc, input int ic);
        obs_t e;
        int ir, icl;
        e = '0;
        ir  = orow * c_st[s] - c_pd[s] + kr;
        icl = ocol * c_st[s] - c_pd[s] + kc;
        e.busy = 1'b1;
        e.s  = is_pad(s, orow, ocol, kr, kc) ? 16'd0 : 16'((ir * c_din[s] + icl) * c_ic[s] + ic);
        e.w  = 16'(((oc * c_k[s] + kr) * c_k[s] + kc) * c_ic[s] + ic);
        e.b  = 16'(oc);
        e.sv = 16'((orow * c_dout[s] + ocol) * c_oc[s] + oc);
        return e;
    endfunction

    // Active-cycle trace of one full layer, from BIAS of the first point to DONE.
    task automatic build(input int s);
        obs_t e;
        exp_q.delete();
        for (int orow = 0; orow < c_dout[s]; orow++)
            for (int ocol = 0; ocol < c_dout[s]; ocol++)
                for (int oc = 0; oc < c_oc[s]; oc++) begin
                    e = mk(s, orow, ocol, oc, 0, 0, 0);
                    e.bias = 1'b1;
                    exp_q.push_back(e);
                    for (int kr = 0; kr < c_k[s]; kr++)
                        for (int kc = 0; kc < c_k[s]; kc++)
                            for (int ic = 0; ic < c_ic[s]; ic++) begin
                                e = mk(s, orow, ocol, oc, kr, kc, ic);
                                if (is_pad(s, orow, ocol, kr, kc)) e.pz = 1'b1;
                                else e.rd = 1'b1;
                                exp_q.push_back(e);
                            end
                    for (int d = 0; d < c_lat[s]; d++)
                        exp_q.push_back(mk(s, orow, ocol, oc, 0, 0, 0));
                    e = mk(s, orow, ocol, oc, 0, 0, 0);
                    e.sat = 1'b1;
                    exp_q.push_back(e);
                    e = mk(s, orow, ocol, oc, 0, 0, 0);
                    e.wr = 1'b1;
                    exp_q.push_back(e);
                end
        e = mk(s, 0, 0, 0, 0, 0, 0);
        e.busy = 1'b0;
        e.done = 1'b1;
        exp_q.push_back(e);
        // Each MAC lands MAC_LAT active cycles after its tap was issued.
        for (int j = exp_q.size() - 1; j >= c_lat[s]; j--)
            if (exp_q[j - c_lat[s]].rd || exp_q[j - c_lat[s]].pz) exp_q[j].mac = 1'b1;
    endtask

    // One layer on DUT s, entered from IDLE at posedge+1; returns at posedge+1 of the next IDLE.
    task automatic run_layer(input int s, input bit stalls, input bit noise, input bit hold,
                             input int x_reads, input int x_pads, input int x_fp_reads,
                             input int x_fp_pads, input int x_fr_s, input int x_fr_w);
        obs_t e;
        int j, cyc, stall_left, busy_cnt, done_cnt, stalled_busy;
        int n_rd, n_pz, n_mac, n_wr, n_bias, fp_rd, fp_pz, fr_s, fr_w;
        bit st, sat_seen, got_first;
        int pts, limit;
        sel = s;
        build(s);
        pts = c_dout[s] * c_dout[s] * c_oc[s];
        j = 0; cyc = 0; stall_left = 0; busy_cnt = 0; done_cnt = 0; stalled_busy = 0;
        n_rd = 0; n_pz = 0; n_mac = 0; n_wr = 0; n_bias = 0; fp_rd = 0; fp_pz = 0;
        fr_s = -1; fr_w = -1; sat_seen = 0; got_first = 0;
        limit = 4 * exp_q.size() + 20;
        stall = 1'b0;
        set_start(1'b1);
        @(negedge clk);
        chk($sformatf("idle_before_start cfg%0d", s), obs, zero_obs);
        @(posedge clk); #1;
        set_start(hold);
        while (j < exp_q.size() && cyc < limit) begin
            st = 1'b0;
            if (stalls) begin
                if (stall_left > 0) begin
                    st = 1'b1;
                    stall_left--;
                end else if ($urandom_range(0, 5) == 0) begin
                    st = 1'b1;
                    stall_left = ($urandom_range(0, 1) == 0) ? 0 : 2;
                end
            end
            stall = st;
            if (noise) set_start(1'($urandom_range(0, 1)));
            @(negedge clk);
            e = exp_q[j];
            if (st) begin
                e.done = 0; e.bias = 0; e.rd = 0; e.pz = 0; e.mac = 0; e.sat = 0; e.wr = 0;
            end
            chk($sformatf("trace cfg%0d step%0d stall%0d", s, j, st), obs, e);
            if (obs.busy) busy_cnt++;
            if (obs.done) done_cnt++;
            if (obs.rd) n_rd++;
            if (obs.pz) n_pz++;
            if (obs.mac) n_mac++;
            if (obs.bias) begin
                chk_int("bias_addr_cycle", int'(obs.b), n_bias % c_oc[s]);
                n_bias++;
            end
            if (obs.wr) begin
                chk_int("save_addr_order", int'(obs.sv), n_wr);
                n_wr++;
            end
            if (!sat_seen) begin
                if (obs.pz) fp_pz++;
                if (obs.rd) begin
                    fp_rd++;
                    if (!got_first) begin
                        got_first = 1'b1;
                        fr_s = int'(obs.s);
                        fr_w = int'(obs.w);
                    end
                end
            end
            if (obs.sat) sat_seen = 1'b1;
            if (st && e.busy) stalled_busy++;
            if (!st) j++;
            cyc++;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        set_start(hold);
        chk_int("trace_complete", j, exp_q.size());
        chk_int("busy_cycles", busy_cnt,
                pts * (c_k[s] * c_k[s] * c_ic[s] + c_lat[s] + 3) + stalled_busy);
        chk_int("done_pulses", done_cnt, 1);
        chk_int("read_count", n_rd, x_reads);
        chk_int("pad_count", n_pz, x_pads);
        chk_int("mac_count", n_mac, x_reads + x_pads);
        chk_int("write_count", n_wr, pts);
        chk_int("first_point_reads", fp_rd, x_fp_reads);
        chk_int("first_point_pads", fp_pz, x_fp_pads);
        chk_int("first_read_s_addr", fr_s, x_fr_s);
        chk_int("first_read_w_addr", fr_w, x_fr_w);
    endtask

    // Controller must stay idle with all outputs zero for n cycles.
    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, obs, zero_obs);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Reset state of both instances.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state_a", obs_a, zero_obs);
        chk("reset_state_b", obs_b, zero_obs);
        @(posedge clk); #1;
        reset_i = 1'b0;
        idle_check("idle_after_reset", 2);

        // A: plain layer, then stalls with start noise.
        run_layer(0, 0, 0, 0, 100, 44, 4, 5, 0, 4);
        idle_check("idle_after_a", 2);
        run_layer(0, 1, 1, 0, 100, 44, 4, 5, 0, 4);
        idle_check("idle_after_a_stall", 2);

        // B: strided, unpadded, multi-channel.
        run_layer(1, 0, 0, 0, 216, 0, 18, 0, 0, 0);
        idle_check("idle_after_b", 2);
        run_layer(1, 1, 1, 0, 216, 0, 18, 0, 0, 0);
        idle_check("idle_after_b_stall", 2);

        // A: reset in the middle of ACC.
        sel = 0;
        build(0);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("pre_reset step%0d", j), obs, exp_q[j]);
            @(posedge clk); #1;
        end
        reset_i = 1'b1;
        #1;
        chk("reset_mid_acc_immediate", obs, zero_obs);
        @(negedge clk);
        chk("reset_mid_acc_held", obs, zero_obs);
        @(posedge clk); #1;
        reset_i = 1'b0;
        idle_check("no_done_after_reset", 3);
        run_layer(0, 0, 0, 0, 100, 44, 4, 5, 0, 4);
        idle_check("idle_after_rerun", 1);

        // A: start held high, two back-to-back layers.
        run_layer(0, 0, 0, 1, 100, 44, 4, 5, 0, 4);
        run_layer(0, 0, 0, 1, 100, 44, 4, 5, 0, 4);
        set_start(1'b0);
        idle_check("idle_after_held", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
